// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS execute core: widths, ALU function codes, immediate helper.
// Optional feature macro: ALU_NOR_EN (alucontrol 011 computes NOR instead of zero).
package mips_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_NOR  = 3'b011;
  localparam logic [2:0] ALU_ANDN = 3'b100;
  localparam logic [2:0] ALU_ORN  = 3'b101;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  function automatic logic [XLEN-1:0] sign_ext16(input logic [15:0] imm);
    return {{(XLEN-16){imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/mips_alu.sv
// Combinational ALU: shared 33-bit adder (bit 2 of alucontrol inverts B and injects carry),
// logic ops, signed SLT, zero flag. Build option ALU_NOR_EN enables NOR on code 011.
module mips_alu
  import mips_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      alucontrol,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            c_out
);

  logic [XLEN-1:0] b_eff;
  logic [XLEN:0]   sum;
  logic            ovf;

  always_comb begin
    b_eff = alucontrol[2] ? ~b : b;
    sum   = {1'b0, a} + {1'b0, b_eff} + {{XLEN{1'b0}}, alucontrol[2]};
    // Overflow: operands (as presented to the adder) agree in sign but the sum does not.
    ovf   = (a[XLEN-1] == b_eff[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);
    c_out = sum[XLEN];

    result = '0;
    case (alucontrol)
      ALU_AND, ALU_ANDN: result = a & b_eff;
      ALU_OR,  ALU_ORN:  result = a | b_eff;
      ALU_ADD, ALU_SUB:  result = sum[XLEN-1:0];
`ifdef ALU_NOR_EN
      ALU_NOR:           result = ~(a | b);
`else
      ALU_NOR:           result = '0;
`endif
      ALU_SLT:           result = {{(XLEN-1){1'b0}}, sum[XLEN-1] ^ ovf};
      default:           result = '0;
    endcase

    zero = (result == '0);
  end

endmodule

// File: rtl/mips_exec_core.sv
// Single-cycle MIPS execute core: 32x32 register file (no write bypass), immediate sign
// extension and the ALU with its operand-B mux. ALU_NOR_EN is forwarded to mips_alu.
module mips_exec_core
  import mips_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reg_write,
  input  logic [REG_ADDR_W-1:0] ra1,
  input  logic [REG_ADDR_W-1:0] ra2,
  input  logic [REG_ADDR_W-1:0] wa,
  input  logic [XLEN-1:0]       wdata,
  input  logic [15:0]           imm16,
  input  logic                  alu_src,
  input  logic [2:0]            alucontrol,
  output logic [XLEN-1:0]       rd1,
  output logic [XLEN-1:0]       rd2,
  output logic [XLEN-1:0]       imm_ext,
  output logic [XLEN-1:0]       alu_result,
  output logic                  zero,
  output logic                  c_out
);

  logic [XLEN-1:0] regs_q [NUM_REGS];
  logic [XLEN-1:0] regs_d [NUM_REGS];
  logic [XLEN-1:0] alu_b;

  always_comb begin
    regs_d = regs_q;
    if (reg_write && (wa != '0)) begin
      regs_d[wa] = wdata;
    end
  end

  // Reset wins over any pending write in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rd1     = (ra1 == '0) ? '0 : regs_q[ra1];
    rd2     = (ra2 == '0) ? '0 : regs_q[ra2];
    imm_ext = sign_ext16(imm16);
    alu_b   = alu_src ? imm_ext : rd2;
  end

  mips_alu u_alu (
    .a          (rd1),
    .b          (alu_b),
    .alucontrol (alucontrol),
    .result     (alu_result),
    .zero       (zero),
    .c_out      (c_out)
  );

endmodule

// File: tb/tb_mips_exec_core.sv
// Directed plus randomized bench for mips_exec_core against an arithmetic reference model.
module tb_mips_exec_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        reg_write;
  logic [4:0]  ra1, ra2, wa;
  logic [31:0] wdata;
  logic [15:0] imm16;
  logic        alu_src;
  logic [2:0]  alucontrol;
  logic [31:0] rd1, rd2, imm_ext, alu_result;
  logic        zero, c_out;

  int checks = 0;
  int errors = 0;

  logic [31:0] mregs [32];

  mips_exec_core dut (
    .clk        (clk),
    .rst        (rst),
    .reg_write  (reg_write),
    .ra1        (ra1),
    .ra2        (ra2),
    .wa         (wa),
    .wdata      (wdata),
    .imm16      (imm16),
    .alu_src    (alu_src),
    .alucontrol (alucontrol),
    .rd1        (rd1),
    .rd2        (rd2),
    .imm_ext    (imm_ext),
    .alu_result (alu_result),
    .zero       (zero),
    .c_out      (c_out)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] addr);
    return (addr == 5'd0) ? 32'd0 : mregs[addr];
  endfunction

  // Reference ALU written from the function table in plain arithmetic.
  task automatic model_alu(input logic [2:0] ctl, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] res, output logic cout);
    logic [63:0] wide;
    wide = 64'(a) + 64'(b);
    cout = ctl[2] ? (a >= b) : wide[32];
    case (ctl)
      3'd0: res = a & b;
      3'd1: res = a | b;
      3'd2: res = a + b;
`ifdef ALU_NOR_EN
      3'd3: res = ~(a | b);
`else
      3'd3: res = 32'd0;
`endif
      3'd4: res = a & ~b;
      3'd5: res = a | ~b;
      3'd6: res = a - b;
      default: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    endcase
  endtask

  task automatic check_all(input string tag);
    logic [31:0] a, b, ie, res;
    logic        cout;
    a  = model_read(ra1);
    ie = {{16{imm16[15]}}, imm16};
    b  = alu_src ? ie : model_read(ra2);
    model_alu(alucontrol, a, b, res, cout);
    check_val({tag, ".rd1"}, rd1, a);
    check_val({tag, ".rd2"}, rd2, model_read(ra2));
    check_val({tag, ".imm_ext"}, imm_ext, ie);
    check_val({tag, ".result"}, alu_result, res);
    check_val({tag, ".zero"}, {31'd0, zero}, {31'd0, res == 32'd0});
    check_val({tag, ".c_out"}, {31'd0, c_out}, {31'd0, cout});
  endtask

  task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    reg_write = 1'b1;
    wa        = addr;
    wdata     = data;
    @(posedge clk);
    if (addr != 5'd0) mregs[addr] = data;
    #1;
    reg_write = 1'b0;
  endtask

  task automatic set_ops(input logic [4:0] a1, input logic [4:0] a2, input logic [15:0] imm,
                         input logic src, input logic [2:0] ctl);
    @(negedge clk);
    ra1 = a1; ra2 = a2; imm16 = imm; alu_src = src; alucontrol = ctl;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b1; reg_write = 1'b0; ra1 = '0; ra2 = '0; wa = '0; wdata = '0;
    imm16 = '0; alu_src = 1'b0; alucontrol = 3'b010;
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;

    // Reset then read.
    do_reset();
    set_ops(5'd5, 5'd31, 16'h0, 1'b0, 3'b010);
    check_val("reset.rd1", rd1, 32'd0);
    check_val("reset.rd2", rd2, 32'd0);
    set_ops(5'd0, 5'd0, 16'h0, 1'b0, 3'b010);
    check_val("reset.result", alu_result, 32'd0);
    check_val("reset.zero", {31'd0, zero}, 32'd1);
    check_val("reset.c_out", {31'd0, c_out}, 32'd0);

    // Write/read and $0 discard.
    write_reg(5'd8, 32'hDEADBEEF);
    set_ops(5'd8, 5'd8, 16'h0, 1'b0, 3'b000);
    check_val("wr.r8", rd1, 32'hDEADBEEF);
    check_val("wr.same_addr", rd2, rd1);
    write_reg(5'd0, 32'h1234);
    set_ops(5'd0, 5'd8, 16'h0, 1'b0, 3'b000);
    check_val("wr.r0", rd1, 32'd0);

    // Same-cycle read sees the old value.
    set_ops(5'd8, 5'd0, 16'h0, 1'b0, 3'b010);
    reg_write = 1'b1; wa = 5'd8; wdata = 32'h1;
    #1;
    check_val("nobypass.old", rd1, 32'hDEADBEEF);
    @(posedge clk);
    mregs[8] = 32'h1;
    #1;
    reg_write = 1'b0;
    check_val("nobypass.new", rd1, 32'h1);

    // Sign extension and immediate add.
    write_reg(5'd1, 32'd10);
    set_ops(5'd1, 5'd0, 16'hFFFC, 1'b1, 3'b010);
    check_val("addi.imm_ext", imm_ext, 32'hFFFFFFFC);
    check_val("addi.result", alu_result, 32'd6);
    check_val("addi.c_out", {31'd0, c_out}, 32'd1);

    // Subtract and zero.
    write_reg(5'd1, 32'd7);
    write_reg(5'd2, 32'd7);
    set_ops(5'd1, 5'd2, 16'h0, 1'b0, 3'b110);
    check_val("sub_eq.result", alu_result, 32'd0);
    check_val("sub_eq.zero", {31'd0, zero}, 32'd1);
    check_val("sub_eq.c_out", {31'd0, c_out}, 32'd1);
    write_reg(5'd2, 32'd8);
    set_ops(5'd1, 5'd2, 16'h0, 1'b0, 3'b110);
    check_val("sub_lt.result", alu_result, 32'hFFFFFFFF);
    check_val("sub_lt.zero", {31'd0, zero}, 32'd0);
    check_val("sub_lt.c_out", {31'd0, c_out}, 32'd0);

    // Signed SLT with overflow.
    write_reg(5'd3, 32'h80000000);
    write_reg(5'd4, 32'h1);
    write_reg(5'd5, 32'h7FFFFFFF);
    write_reg(5'd6, 32'hFFFFFFFF);
    set_ops(5'd3, 5'd4, 16'h0, 1'b0, 3'b111);
    check_val("slt_neg.result", alu_result, 32'd1);
    set_ops(5'd5, 5'd6, 16'h0, 1'b0, 3'b111);
    check_val("slt_pos.result", alu_result, 32'd0);

    // Logic ops.
    write_reg(5'd9, 32'hF0F0F0F0);
    write_reg(5'd10, 32'h0FF00FF0);
    set_ops(5'd9, 5'd10, 16'h0, 1'b0, 3'b000);
    check_val("and.result", alu_result, 32'h00F000F0);
    set_ops(5'd9, 5'd10, 16'h0, 1'b0, 3'b001);
    check_val("or.result", alu_result, 32'hFFF0FFF0);
    set_ops(5'd9, 5'd10, 16'h0, 1'b0, 3'b100);
    check_val("andn.result", alu_result, 32'hF000F000);
    set_ops(5'd9, 5'd10, 16'h0, 1'b0, 3'b011);
`ifdef ALU_NOR_EN
    check_val("nor.result", alu_result, 32'h000F000F);
    check_val("nor.zero", {31'd0, zero}, 32'd0);
`else
    check_val("nor_off.result", alu_result, 32'd0);
    check_val("nor_off.zero", {31'd0, zero}, 32'd1);
`endif
    check_all("logic_model");

    // Randomized writes and operations checked against the model.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) != 0) begin
        write_reg(5'($urandom_range(0, 31)), $urandom());
      end
      set_ops(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 16'($urandom()),
              1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      check_all($sformatf("rand%0d", i));
    end

    // Reset during a write: the write is discarded and everything clears.
    @(negedge clk);
    reg_write = 1'b1; wa = 5'd12; wdata = 32'hCAFEF00D; rst = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    #1;
    rst = 1'b1; reg_write = 1'b0;
    set_ops(5'd12, 5'd9, 16'h8000, 1'b0, 3'b010);
    check_val("midreset.r12", rd1, 32'd0);
    check_val("midreset.r9", rd2, 32'd0);
    check_all("midreset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
